sha3_scan_result_collector: RTL and testbench

//  Downstream of the SHA3 scanner: captures every hit (found + nonce + leading hash words) into a

---
 rtl/sha3_scan_result_collector.sv | 168 ++++++++++++++++
 tb/tb_sha3_scan_result_collector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sha3_scan_result_collector.sv
// sha3_scan_result_collector
// Collects SHA3 scanner hits (nonce + leading hash words) into a small FIFO,
// presents them on a valid/ready stream, tracks the scan lifecycle and keeps
// hit/drop statistics.
//
// Handshake: the head entry is offered while res_valid=1 and is consumed on a
// clock edge where res_valid & res_ready are both 1; res_* stay stable while
// res_valid & !res_ready; res_* read as 0 whenever the FIFO is empty.
module sha3_scan_result_collector #(
    parameter int DEPTH      = 4,
    parameter int HASH_WORDS = 2
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic                         dispatching,
    input  logic                         evaluating,
    input  logic                         found,
    input  logic [49:0][31:0]            hash,
    input  logic [31:0]                  nonce,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [31:0]                  res_nonce,
    output logic [HASH_WORDS-1:0][31:0]  res_hash,
    output logic                         scanning,
    output logic                         scan_done,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  drop_count,
    output logic                         spurious,
    input  logic                         clear_stats
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic                       scan_done_q, scan_done_d;
    logic [AW:0]                wr_ptr_q, wr_ptr_d;
    logic [AW:0]                rd_ptr_q, rd_ptr_d;
    logic [31:0]                nonce_mem_q [DEPTH];
    logic [31:0]                nonce_mem_d [DEPTH];
    logic [HASH_WORDS-1:0][31:0] hash_mem_q [DEPTH];
    logic [HASH_WORDS-1:0][31:0] hash_mem_d [DEPTH];
    logic [31:0]                hit_count_q, hit_count_d;
    logic [31:0]                drop_count_q, drop_count_d;
    logic                       spurious_q, spurious_d;

    logic fifo_empty, fifo_full;
    logic push_req, push_ok, push_drop, pop;
    logic spurious_set;

    // Words beyond HASH_WORDS are not stored; fold them so the port stays connected.
    logic unused_hash;
    assign unused_hash = ^hash;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Hit qualification, FIFO push/pop decisions and the scan FSM next state.
    always_comb begin
        state_d      = state_q;
        scan_done_d  = 1'b0;
        // A hit on the IDLE->RUN edge already belongs to the scan.
        push_req     = found && ((state_q != ST_IDLE) || dispatching);
        spurious_set = found && (state_q == ST_IDLE) && !dispatching;
        pop          = res_ready && !fifo_empty;
        push_ok      = push_req && (!fifo_full || pop);
        push_drop    = push_req && fifo_full && !pop;

        case (state_q)
            ST_IDLE: begin
                if (dispatching) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!dispatching) begin
                    state_d     = evaluating ? ST_TAIL : ST_IDLE;
                    scan_done_d = !evaluating;
                end
            end
            ST_TAIL: begin
                if (dispatching) begin
                    state_d = ST_RUN;
                end else if (!evaluating) begin
                    state_d     = ST_IDLE;
                    scan_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO storage and pointer updates.
    always_comb begin
        nonce_mem_d = nonce_mem_q;
        hash_mem_d  = hash_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push_ok) begin
            nonce_mem_d[wr_ptr_q[AW-1:0]] = nonce;
            hash_mem_d[wr_ptr_q[AW-1:0]]  = hash[HASH_WORDS-1:0];
            wr_ptr_d                      = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Statistics: saturating counters and sticky spurious flag; a clear always wins.
    always_comb begin
        hit_count_d  = hit_count_q;
        drop_count_d = drop_count_q;
        spurious_d   = spurious_q | spurious_set;
        if (push_ok && (hit_count_q != 32'hFFFF_FFFF)) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (push_drop && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_d = drop_count_q + 32'd1;
        end
        if (clear_stats) begin
            hit_count_d  = 32'd0;
            drop_count_d = 32'd0;
            spurious_d   = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            scan_done_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hit_count_q  <= 32'd0;
            drop_count_q <= 32'd0;
            spurious_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                nonce_mem_q[i] <= 32'd0;
                hash_mem_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            scan_done_q  <= scan_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hit_count_q  <= hit_count_d;
            drop_count_q <= drop_count_d;
            spurious_q   <= spurious_d;
            nonce_mem_q  <= nonce_mem_d;
            hash_mem_q   <= hash_mem_d;
        end
    end

    // Outputs: head entry when non-empty, zero otherwise.
    always_comb begin
        res_valid  = !fifo_empty;
        res_nonce  = fifo_empty ? 32'd0 : nonce_mem_q[rd_ptr_q[AW-1:0]];
        res_hash   = fifo_empty ? '0    : hash_mem_q[rd_ptr_q[AW-1:0]];
        scanning   = (state_q != ST_IDLE);
        scan_done  = scan_done_q;
        hit_count  = hit_count_q;
        drop_count = drop_count_q;
        spurious   = spurious_q;
    end

endmodule

// File: tb/tb_sha3_scan_result_collector.sv
// Self-checking bench for sha3_scan_result_collector: directed scenarios plus
// randomized traffic, compared every cycle against a queue-based reference.
module tb_sha3_scan_result_collector;

  localparam int DEPTH = 4;
  localparam int HW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 dispatching = 1'b0;
  logic                 evaluating = 1'b0;
  logic                 found = 1'b0;
  logic [49:0][31:0]    hash = '0;
  logic [31:0]          nonce = 32'd0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic [31:0]          res_nonce;
  logic [HW-1:0][31:0]  res_hash;
  logic                 scanning;
  logic                 scan_done;
  logic [31:0]          hit_count;
  logic [31:0]          drop_count;
  logic                 spurious;
  logic                 clear_stats = 1'b0;

  sha3_scan_result_collector #(.DEPTH(DEPTH), .HASH_WORDS(HW)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .dispatching  (dispatching),
    .evaluating   (evaluating),
    .found        (found),
    .hash         (hash),
    .nonce        (nonce),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_nonce    (res_nonce),
    .res_hash     (res_hash),
    .scanning     (scanning),
    .scan_done    (scan_done),
    .hit_count    (hit_count),
    .drop_count   (drop_count),
    .spurious     (spurious),
    .clear_stats  (clear_stats)
  );

  // ---------------- scoreboard / reference ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int done_pulses = 0;

  logic [95:0] exp_q[$];   // {nonce, hash[1], hash[0]}
  bit          m_scanning;
  bit          m_done;
  bit          m_spur;
  logic [31:0] m_hits;
  logic [31:0] m_drops;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_scanning = 1'b0;
    m_done     = 1'b0;
    m_spur     = 1'b0;
    m_hits     = 32'd0;
    m_drops    = 32'd0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock edge of the reference, computed from the pre-edge inputs.
  task automatic model_step(input bit disp, input bit eval, input bit fnd, input bit rdy,
                            input bit clr, input logic [31:0] nn, input logic [31:0] h0,
                            input logic [31:0] h1);
    bit in_scan, push, pop, accepted, spur_hit;
    in_scan  = m_scanning || disp;
    push     = fnd && in_scan;
    spur_hit = fnd && !in_scan;
    pop      = rdy && (exp_q.size() > 0);
    accepted = push && ((exp_q.size() < DEPTH) || pop);
    if (pop) void'(exp_q.pop_front());
    if (accepted) exp_q.push_back({nn, h1, h0});
    if (clr) begin
      m_hits  = 32'd0;
      m_drops = 32'd0;
      m_spur  = 1'b0;
    end else begin
      if (accepted) m_hits = sat_inc(m_hits);
      if (push && !accepted) m_drops = sat_inc(m_drops);
      if (spur_hit) m_spur = 1'b1;
    end
    // A scan ends when nothing is being dispatched and nothing is left in flight.
    m_done     = m_scanning && !disp && !eval;
    m_scanning = disp || (m_scanning && eval);
  endtask

  task automatic check_all();
    logic [95:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 96'd0;
    check("res_valid",  res_valid,  exp_q.size() > 0);
    check("res_nonce",  res_nonce,  head[95:64]);
    check("res_hash",   res_hash,   head[63:0]);
    check("scanning",   scanning,   m_scanning);
    check("scan_done",  scan_done,  m_done);
    check("hit_count",  hit_count,  m_hits);
    check("drop_count", drop_count, m_drops);
    check("spurious",   spurious,   m_spur);
    if (scan_done) done_pulses++;
  endtask

  // ---------------- driver ----------------
  // Drives inputs (called right after a negedge), steps the model at the
  // posedge and checks at the following negedge.
  task automatic cycle(input bit disp, input bit eval, input bit fnd, input bit rdy,
                       input bit clr, input logic [31:0] nn, input logic [31:0] h0,
                       input logic [31:0] h1);
    dispatching = disp;
    evaluating  = eval;
    found       = fnd;
    res_ready   = rdy;
    clear_stats = clr;
    nonce       = nn;
    for (int i = 2; i < 50; i++) hash[i] = $urandom;
    hash[0] = h0;
    hash[1] = h1;
    @(posedge clk);
    model_step(disp, eval, fnd, rdy, clr, nn, h0, h1);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();                       // reset values
    rst_n = 1'b1;
    idle_cycles(2);

    // Scan lifecycle: 10 dispatching cycles, 5 evaluating cycles, no hits.
    done_pulses = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++)  cycle(0, 1, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    idle_cycles(3);
    check("scan_done_pulses", done_pulses, 1);

    // Single hit, held until the host is ready.
    cycle(1, 0, 1, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    check("hit_nonce", res_nonce, 32'h0000_1234);
    check("hit_hash0", res_hash[0], 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    cycle(1, 0, 0, 1, 0, 32'd0, 32'd0, 32'd0);
    check("hit_popped", res_valid, 1'b0);
    cycle(0, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0);

    // Overflow: six back-to-back hits into a 4-deep FIFO.
    for (int i = 1; i <= 6; i++) cycle(1, 0, 1, 0, 0, i, 32'hA000_0000 + i, 32'hB000_0000 + i);
    check("ovf_hits", hit_count, 32'd4);
    check("ovf_drops", drop_count, 32'd2);
    // Full FIFO: simultaneous pop and push keeps order and drops nothing.
    cycle(1, 0, 1, 1, 0, 32'd7, 32'hA000_0007, 32'hB000_0007);
    check("fullpp_drops", drop_count, 32'd2);
    check("fullpp_head", res_nonce, 32'd2);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 0, 32'd0, 32'd0, 32'd0);
    idle_cycles(2);

    // Spurious hit while idle; sticky until cleared.
    cycle(0, 0, 1, 0, 0, 32'h5555, 32'h1, 32'h2);
    check("spur_set", spurious, 1'b1);
    check("spur_empty", res_valid, 1'b0);
    idle_cycles(3);
    cycle(0, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0);
    check("spur_clr", spurious, 1'b0);

    // Reset in the middle of a scan with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 32'h100 + i, $urandom, $urandom);
    dispatching = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", res_valid, 1'b0);
    check("arst_nonce", res_nonce, 32'd0);
    check("arst_hash", res_hash, 64'd0);
    check("arst_scanning", scanning, 1'b0);
    check("arst_hits", hit_count, 32'd0);
    dispatching = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 3, $urandom, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
